td4_seg_scan: RTL and testbench

- Time-multiplexed driver for the TD4 board's 3-digit 7-segment display.
- Takes three 4-bit values from the CPU/debug side, hex-decodes them and scans them onto the shared segment bus.
- Drives the shared segment bus SEG_O and the digit enables DP1OEN_O..DP3OEN_O directly.
- Data updates are double-buffered and applied only at frame boundaries, so the display never tears. A guard interval between digits suppresses ghosting.

---
 rtl/td4_pkg.sv | 28 ++
 rtl/td4_hex7seg.sv | 11 +
 rtl/td4_seg_scan.sv | 158 +++++++++++++++
 tb/tb_td4_seg_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared constants and types for the TD4 3-digit 7-segment scanner.
package td4_pkg;

   localparam int unsigned NIB_W = 4;
   localparam int unsigned NDIG  = 3;
   localparam int unsigned SEG_W = 8;

   // Active-high gfedcba glyphs for hex digits 0..F
   localparam logic [6:0] HEX7SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

   typedef enum logic [1:0] {
      DIG1 = 2'd0,
      DIG2 = 2'd1,
      DIG3 = 2'd2
   } dig_e;

   typedef struct packed {
      logic [NDIG*NIB_W-1:0] data;
      logic [NDIG-1:0]       dpt;
      logic [NDIG-1:0]       blank;
   } disp_t;

endpackage

// File: rtl/td4_hex7seg.sv
// Combinational nibble to active-high 7-segment (gfedcba) decoder.
module td4_hex7seg
   import td4_pkg::*;
(
   input  logic [NIB_W-1:0] nib_i,
   output logic [6:0]       seg_c_o
);

   assign seg_c_o = HEX7SEG[nib_i];

endmodule

// File: rtl/td4_seg_scan.sv
// Time-multiplexed 3-digit 7-segment scanner with frame-synchronous
// double-buffered display data and an inter-digit ghosting guard.
module td4_seg_scan
   import td4_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned GHOST_CYC   = 8,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          DIG_ACT_LOW = 1'b1
) (
   input  logic                    CLK_I,
   input  logic                    RSTN_I,
   input  logic [NDIG*NIB_W-1:0]   DATA_I,
   input  logic [NDIG-1:0]         DPT_I,
   input  logic [NDIG-1:0]         BLANK_I,
   input  logic                    LOAD_I,
   output logic [SEG_W-1:0]        SEG_O,
   output logic                    DP1OEN_O,
   output logic                    DP2OEN_O,
   output logic                    DP3OEN_O,
   output logic                    FRAME_O
);

   localparam int unsigned     PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]   P_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]   P_GHOST  = PW'(GHOST_CYC);
   localparam logic [SEG_W-1:0] SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [NDIG-1:0] EN_IDLE  = DIG_ACT_LOW ? 3'b111 : 3'b000;

   dig_e              idx_q;
   logic [PW-1:0]     p_q, p_d;
   disp_t             shadow_q, shadow_d;
   disp_t             disp_q, disp_d;
   disp_t             in_c;
   logic              pend_q, pend_d;
   logic              wrap_q, frame_q;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic [NDIG-1:0]   en_q, en_d;
   logic              slot_end_c, boundary_c;
   logic [NIB_W-1:0]  nib_c;
   logic              dp_c, blank_c;
   logic [NDIG-1:0]   en_hi_c;
   logic [SEG_W-1:0]  seg_hi_c;
   logic [6:0]        hex_c;

   assign in_c       = {DATA_I, DPT_I, BLANK_I};
   assign slot_end_c = (p_q == P_LAST);
   assign boundary_c = (idx_q == DIG3) && slot_end_c;

   // Prescaler and shadow/display buffering; a boundary load bypasses the shadow
   always_comb begin
      p_d      = slot_end_c ? '0 : p_q + PW'(1);
      shadow_d = shadow_q;
      disp_d   = disp_q;
      pend_d   = pend_q;
      if (LOAD_I) begin
         shadow_d = in_c;
         if (boundary_c) begin
            disp_d = in_c;
            pend_d = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end else if (boundary_c && pend_q) begin
         disp_d = shadow_q;
         pend_d = 1'b0;
      end
   end

   // Digit mux; an out-of-range index shows nothing
   always_comb begin
      nib_c   = '0;
      dp_c    = 1'b0;
      blank_c = 1'b1;
      en_hi_c = '0;
      case (idx_q)
         DIG1: begin
            nib_c   = disp_q.data[3:0];
            dp_c    = disp_q.dpt[0];
            blank_c = disp_q.blank[0];
            en_hi_c = 3'b001;
         end
         DIG2: begin
            nib_c   = disp_q.data[7:4];
            dp_c    = disp_q.dpt[1];
            blank_c = disp_q.blank[1];
            en_hi_c = 3'b010;
         end
         DIG3: begin
            nib_c   = disp_q.data[11:8];
            dp_c    = disp_q.dpt[2];
            blank_c = disp_q.blank[2];
            en_hi_c = 3'b100;
         end
         default: ;
      endcase
   end

   td4_hex7seg u_hex (
      .nib_i   (nib_c),
      .seg_c_o (hex_c)
   );

   always_comb begin
      seg_hi_c = {dp_c, hex_c};
      en_d     = en_hi_c;
      if ((p_q < P_GHOST) || blank_c) begin
         seg_hi_c = SEG_OFF;
         en_d     = '0;
      end
      seg_d = SEG_ACT_LOW ? ~seg_hi_c : seg_hi_c;
      if (DIG_ACT_LOW) en_d = ~en_d;
   end

   // Digit-index FSM; the unused encoding falls back to DIG1
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         idx_q <= DIG1;
      end else begin
         case (idx_q)
            DIG1:    if (slot_end_c) idx_q <= DIG2;
            DIG2:    if (slot_end_c) idx_q <= DIG3;
            DIG3:    if (slot_end_c) idx_q <= DIG1;
            default: idx_q <= DIG1;
         endcase
      end
   end

   // Frame pulse lags the boundary by two so it lines up with digit1's guard on the pins
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         p_q      <= '0;
         shadow_q <= '0;
         disp_q   <= '0;
         pend_q   <= 1'b0;
         wrap_q   <= 1'b0;
         frame_q  <= 1'b0;
         seg_q    <= SEG_IDLE;
         en_q     <= EN_IDLE;
      end else begin
         p_q      <= p_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         wrap_q   <= boundary_c;
         frame_q  <= wrap_q;
         seg_q    <= seg_d;
         en_q     <= en_d;
      end
   end

   assign SEG_O    = seg_q;
   assign DP1OEN_O = en_q[0];
   assign DP2OEN_O = en_q[1];
   assign DP3OEN_O = en_q[2];
   assign FRAME_O  = frame_q;

endmodule

// File: tb/tb_td4_seg_scan.sv
// Self-checking bench for td4_seg_scan: both output polarities against a frame-level model.
module tb_td4_seg_scan;

   localparam int unsigned SD    = 8;
   localparam int unsigned GC    = 2;
   localparam int unsigned FRAME = 3 * SD;

   // Active-low glyphs with dp off, straight from the datasheet table
   localparam logic [7:0] HEXLO [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic        clk = 1'b0;
   logic        rstn;
   logic [11:0] data;
   logic [2:0]  dpt, blank;
   logic        load;
   logic [7:0]  seg, seg_h;
   logic        dp1, dp2, dp3, frame;
   logic        dh1, dh2, dh3, frame_h;

   int total = 0;
   int bad   = 0;

   int          m_cnt;
   logic [11:0] m_data, s_data;
   logic [2:0]  m_dpt, m_blank, s_dpt, s_blank;
   bit          m_pend, m_wrap;
   logic [7:0]  e_seg;
   logic [2:0]  e_en;
   logic        e_fr;

   always #5 clk = ~clk;

   td4_seg_scan #(.SCAN_DIV(SD), .GHOST_CYC(GC), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut (
      .CLK_I(clk), .RSTN_I(rstn), .DATA_I(data), .DPT_I(dpt), .BLANK_I(blank),
      .LOAD_I(load), .SEG_O(seg), .DP1OEN_O(dp1), .DP2OEN_O(dp2), .DP3OEN_O(dp3),
      .FRAME_O(frame)
   );

   td4_seg_scan #(.SCAN_DIV(SD), .GHOST_CYC(GC), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_h (
      .CLK_I(clk), .RSTN_I(rstn), .DATA_I(data), .DPT_I(dpt), .BLANK_I(blank),
      .LOAD_I(load), .SEG_O(seg_h), .DP1OEN_O(dh1), .DP2OEN_O(dh2), .DP3OEN_O(dh3),
      .FRAME_O(frame_h)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // One clock: advance the model on the edge, then compare both DUTs
   task automatic step();
      int slot, ph;
      @(posedge clk);
      if (!rstn) begin
         e_seg   = 8'hFF;
         e_en    = 3'b111;
         e_fr    = 1'b0;
         m_cnt   = 0;
         m_data  = '0; m_dpt = '0; m_blank = '0;
         s_data  = '0; s_dpt = '0; s_blank = '0;
         m_pend  = 1'b0;
         m_wrap  = 1'b0;
      end else begin
         slot  = m_cnt / SD;
         ph    = m_cnt % SD;
         e_seg = 8'hFF;
         e_en  = 3'b111;
         if (ph >= GC && !m_blank[slot]) begin
            e_seg      = (HEXLO[m_data[slot*4 +: 4]] & 8'h7F) | (m_dpt[slot] ? 8'h00 : 8'h80);
            e_en[slot] = 1'b0;
         end
         e_fr   = m_wrap;
         m_wrap = (m_cnt == FRAME - 1);
         if (load) begin
            s_data = data; s_dpt = dpt; s_blank = blank;
            if (m_cnt == FRAME - 1) begin
               m_data = data; m_dpt = dpt; m_blank = blank;
               m_pend = 1'b0;
            end else begin
               m_pend = 1'b1;
            end
         end else if (m_cnt == FRAME - 1 && m_pend) begin
            m_data = s_data; m_dpt = s_dpt; m_blank = s_blank;
            m_pend = 1'b0;
         end
         m_cnt = (m_cnt + 1) % FRAME;
      end
      #1;
      check("seg",     seg,                   e_seg);
      check("en",      {5'b0, dp3, dp2, dp1}, {5'b0, e_en});
      check("frame",   {7'b0, frame},         {7'b0, e_fr});
      check("seg_h",   seg_h,                 ~e_seg);
      check("en_h",    {5'b0, dh3, dh2, dh1}, {5'b0, ~e_en});
      check("frame_h", {7'b0, frame_h},       {7'b0, e_fr});
   endtask

   // Step until the scan position reaches c; pins then show position c-1
   task automatic run_to(input int c);
      int n = 0;
      while (m_cnt != c && n < 30) begin
         step();
         n++;
      end
      if (m_cnt != c) check("run_to_timeout", 8'(m_cnt), 8'(c));
   endtask

   task automatic do_load(input logic [11:0] d, input logic [2:0] p, input logic [2:0] b);
      data = d; dpt = p; blank = b; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; data = '0; dpt = '0; blank = '0; load = 1'b0;
      m_cnt = 0; m_pend = 1'b0; m_wrap = 1'b0;
      repeat (3) step();
      check("rst_seg", seg, 8'hFF);
      check("rst_en",  {5'b0, dp3, dp2, dp1}, 8'h07);
      rstn = 1'b1;

      // Idle scan with zero display
      repeat (50) step();
      run_to(5);
      check("t1_d1", seg, 8'hC0);
      check("t1_en", {5'b0, dp3, dp2, dp1}, 8'h06);

      // Mid-frame load waits for the next frame
      run_to(12);
      do_load(12'hA81, 3'b010, 3'b000);
      run_to(14);
      check("t2_old", seg, 8'hC0);
      run_to(0);
      run_to(5);
      check("t2_d1", seg, 8'hF9);
      run_to(13);
      check("t2_d2", seg, 8'h00);
      run_to(21);
      check("t2_d3", seg, 8'h88);

      // Boundary load applies at once and discards the pending one
      run_to(4);
      do_load(12'h123, 3'b000, 3'b000);
      run_to(23);
      do_load(12'hF00, 3'b000, 3'b000);
      run_to(5);
      check("t3_d1", seg, 8'hC0);
      run_to(21);
      check("t3_d3", seg, 8'h8E);

      // Blanked digit2
      run_to(10);
      do_load(12'h321, 3'b000, 3'b010);
      run_to(0);
      run_to(5);
      check("t4_d1", seg, 8'hF9);
      run_to(13);
      check("t4_d2", seg, 8'hFF);
      check("t4_en2", {7'b0, dp2}, 8'h01);
      run_to(21);
      check("t4_d3", seg, 8'hB0);

      // Reset during digit2 ON
      run_to(13);
      rstn = 1'b0;
      step();
      check("t5_seg", seg, 8'hFF);
      check("t5_en", {5'b0, dp3, dp2, dp1}, 8'h07);
      rstn = 1'b1;
      run_to(5);
      check("t5_d1", seg, 8'hC0);
      check("t5_en1", {5'b0, dp3, dp2, dp1}, 8'h06);

      // Active-high instance
      run_to(3);
      do_load(12'h888, 3'b000, 3'b000);
      run_to(0);
      run_to(5);
      check("t6_seg", seg_h, 8'h7F);
      check("t6_en", {5'b0, dh3, dh2, dh1}, 8'h01);
      run_to(1);
      check("t6_idle", seg_h, 8'h00);
      check("t6_frame", {7'b0, frame_h}, 8'h01);

      // Random loads, occasional boundary loads and resets
      for (int i = 0; i < 1500; i++) begin
         rstn  = ($urandom_range(0, 299) != 0);
         load  = ($urandom_range(0, 5) == 0);
         data  = 12'($urandom);
         dpt   = 3'($urandom);
         blank = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         step();
      end
      rstn = 1'b1;
      load = 1'b0;
      repeat (30) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
